// File: rtl/valve_sequencer.sv
// Purpose : fetch/decode/execute sequencer driving a 16-bit valve bank from a synchronous program ROM.
// Latency : 2 cycles per instruction (FETCH + EXEC); timed DELAY adds delay*BASE_TICKS*M cycles.
// Backpr. : none; start is ignored while busy, step is honoured only in WAIT_STEP, abort always wins.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort, step    control pulses (abort > start/step)
//   imem_addr/imem_rdata  program ROM port, data valid one cycle after the address
//   valves                registered valve drive
//   pc                    program counter
//   busy/halted/wait_step registered status
//   done                  one-cycle pulse when HALT executes
module valve_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int BASE_TICKS = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [20:0]       imem_rdata,
  output logic [15:0]       valves,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              wait_step,
  output logic              done
);

  localparam int BW = $clog2(BASE_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT_DELAY,
    S_WAIT_STEP,
    S_HALTED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [15:0]       r_valves;
  logic [15:0]       w_valves_nxt;
  logic [9:0]        r_remaining;
  logic [9:0]        w_remaining_nxt;
  logic [9:0]        r_decade;
  logic [9:0]        w_decade_nxt;
  logic [9:0]        r_dec_max;
  logic [9:0]        w_dec_max_nxt;
  logic [BW-1:0]     r_base;
  logic [BW-1:0]     w_base_nxt;
  logic              r_busy;
  logic              r_halted;
  logic              r_wait_step;
  logic              r_done;
  logic              w_done_nxt;

  // Instruction fields
  logic [2:0] w_op;
  logic [3:0] w_valve;
  logic [9:0] w_delay;
  logic [2:0] w_unit;
  logic       w_bit0;

  assign w_op     = imem_rdata[20:18];
  assign w_valve  = imem_rdata[17:14];
  assign w_delay  = imem_rdata[13:4];
  assign w_unit   = imem_rdata[3:1];
  assign w_bit0   = imem_rdata[0];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Decade terminal count (M-1) per time unit; units above 3 behave like unit 0.
  function automatic logic [9:0] unit_dec_max(input logic [2:0] unit);
    case (unit)
      3'd1:    unit_dec_max = 10'd9;
      3'd2:    unit_dec_max = 10'd99;
      3'd3:    unit_dec_max = 10'd999;
      default: unit_dec_max = 10'd0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_valves_nxt    = r_valves;
    w_remaining_nxt = r_remaining;
    w_decade_nxt    = r_decade;
    w_dec_max_nxt   = r_dec_max;
    w_base_nxt      = r_base;
    w_done_nxt      = 1'b0;

    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_pc_nxt        = '0;
      w_valves_nxt    = '0;
      w_remaining_nxt = '0;
      w_decade_nxt    = '0;
      w_dec_max_nxt   = '0;
      w_base_nxt      = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_pc_nxt = '0;
          if (start) w_state_nxt = S_FETCH;
        end
        S_FETCH: w_state_nxt = S_EXEC;
        S_EXEC: begin
          case (w_op)
            3'b000: begin
              w_state_nxt = S_HALTED;
              w_done_nxt  = 1'b1;
            end
            3'b001: begin
              w_valves_nxt[w_valve] = w_bit0;
              w_pc_nxt              = w_pc_inc;
              w_state_nxt           = S_FETCH;
            end
            3'b010: begin
              if (w_bit0) begin
                w_state_nxt = S_WAIT_STEP;
              end else if (w_delay == 10'd0) begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
              end else begin
                w_remaining_nxt = w_delay;
                w_decade_nxt    = '0;
                w_base_nxt      = '0;
                w_dec_max_nxt   = unit_dec_max(w_unit);
                w_state_nxt     = S_WAIT_DELAY;
              end
            end
            default: begin
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = S_FETCH;
            end
          endcase
        end
        S_WAIT_DELAY: begin
          if (r_base == BW'(BASE_TICKS - 1)) begin
            w_base_nxt = '0;
            if (r_decade == r_dec_max) begin
              w_decade_nxt    = '0;
              w_remaining_nxt = r_remaining - 10'd1;
              // Last decrement ends the wait; counters are all back at zero.
              if (r_remaining == 10'd1) begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
              end
            end else begin
              w_decade_nxt = r_decade + 10'd1;
            end
          end else begin
            w_base_nxt = r_base + BW'(1);
          end
        end
        S_WAIT_STEP: begin
          if (step) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        end
        S_HALTED: begin
          if (start) begin
            w_pc_nxt    = '0;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Status flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_valves    <= '0;
      r_remaining <= '0;
      r_decade    <= '0;
      r_dec_max   <= '0;
      r_base      <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_wait_step <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_valves    <= w_valves_nxt;
      r_remaining <= w_remaining_nxt;
      r_decade    <= w_decade_nxt;
      r_dec_max   <= w_dec_max_nxt;
      r_base      <= w_base_nxt;
      r_busy      <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) ||
                     (w_state_nxt == S_WAIT_DELAY) || (w_state_nxt == S_WAIT_STEP);
      r_halted    <= (w_state_nxt == S_HALTED);
      r_wait_step <= (w_state_nxt == S_WAIT_STEP);
      r_done      <= w_done_nxt;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign valves    = r_valves;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign wait_step = r_wait_step;
  assign done      = r_done;

endmodule
